// File: rtl/filter_pkg.sv
// Shared definitions for the filter pipeline: default pixel width and a helper
// that sizes raster counters from an image dimension.
package filter_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Width needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/filter_line_buffer.sv
// One image line of delay: a single-port memory addressed by column that
// returns the old contents of the addressed slot while the new pixel is written.
module filter_line_buffer
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 640,
    parameter int AW         = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Contents are never cleared; the window gating upstream hides stale lines.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign data_o = mem[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem[addr_i] <= data_i;
        end
    end

endmodule

// File: rtl/filter_window_5x5.sv
// Raster stream to 5x5 neighbourhood converter. Emits only fully populated
// windows, one cycle after the pixel that completes them is accepted.
module filter_window_5x5
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_fs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_de,
    output logic                  o_eof,
    output logic [DATA_WIDTH-1:0] o_x00, o_x01, o_x02, o_x03, o_x04,
    output logic [DATA_WIDTH-1:0] o_x10, o_x11, o_x12, o_x13, o_x14,
    output logic [DATA_WIDTH-1:0] o_x20, o_x21, o_x22, o_x23, o_x24,
    output logic [DATA_WIDTH-1:0] o_x30, o_x31, o_x32, o_x33, o_x34,
    output logic [DATA_WIDTH-1:0] o_x40, o_x41, o_x42, o_x43, o_x44
);

    localparam int CW = cnt_width(H_ACTIVE);
    localparam int RW = cnt_width(V_ACTIVE);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          active_q, active_d;
    logic          de_q, de_d;
    logic          eof_q, eof_d;
    logic          accept, last_px;

    logic [DATA_WIDTH-1:0] lb_rd  [4];
    logic [DATA_WIDTH-1:0] lb_wr  [4];
    logic [DATA_WIDTH-1:0] col_new[5];
    logic [DATA_WIDTH-1:0] win_q  [5][5];

    // A frame-start pixel is position (0,0) regardless of where the counters were.
    always_comb begin
        cur_col = i_fs ? '0 : col_q;
        cur_row = i_fs ? '0 : row_q;
        accept  = i_de & (i_fs | active_q);
        last_px = (cur_row == RW'(V_ACTIVE - 1)) && (cur_col == CW'(H_ACTIVE - 1));
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        active_d = active_q;
        de_d     = 1'b0;
        eof_d    = 1'b0;
        if (accept) begin
            active_d = 1'b1;
            de_d     = (cur_row >= RW'(4)) && (cur_col >= CW'(4));
            if (last_px) begin
                col_d    = '0;
                row_d    = '0;
                active_d = 1'b0;
                eof_d    = 1'b1;
            end else if (cur_col == CW'(H_ACTIVE - 1)) begin
                col_d = '0;
                row_d = cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q    <= '0;
            row_q    <= '0;
            active_q <= 1'b0;
            de_q     <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            active_q <= active_d;
            de_q     <= de_d;
            eof_q    <= eof_d;
        end
    end

    // LB0 holds the previous line, LB3 the line four rows back.
    assign lb_wr[0]   = i_data;
    assign col_new[4] = i_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lb
        if (gi > 0) begin : g_chain
            assign lb_wr[gi] = lb_rd[gi-1];
        end
        assign col_new[3-gi] = lb_rd[gi];

        filter_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (H_ACTIVE),
            .AW        (CW)
        ) u_lb (
            .clk   (clk),
            .en_i  (accept),
            .addr_i(cur_col),
            .data_i(lb_wr[gi]),
            .data_o(lb_rd[gi])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][4] <= col_new[r];
            end
        end
    end

    assign o_de  = de_q;
    assign o_eof = eof_q;

    assign o_x00 = win_q[0][0]; assign o_x01 = win_q[0][1]; assign o_x02 = win_q[0][2];
    assign o_x03 = win_q[0][3]; assign o_x04 = win_q[0][4];
    assign o_x10 = win_q[1][0]; assign o_x11 = win_q[1][1]; assign o_x12 = win_q[1][2];
    assign o_x13 = win_q[1][3]; assign o_x14 = win_q[1][4];
    assign o_x20 = win_q[2][0]; assign o_x21 = win_q[2][1]; assign o_x22 = win_q[2][2];
    assign o_x23 = win_q[2][3]; assign o_x24 = win_q[2][4];
    assign o_x30 = win_q[3][0]; assign o_x31 = win_q[3][1]; assign o_x32 = win_q[3][2];
    assign o_x33 = win_q[3][3]; assign o_x34 = win_q[3][4];
    assign o_x40 = win_q[4][0]; assign o_x41 = win_q[4][1]; assign o_x42 = win_q[4][2];
    assign o_x43 = win_q[4][3]; assign o_x44 = win_q[4][4];

endmodule

// File: tb/tb_filter_window_5x5.sv
// Randomized bench for the 5x5 window generator on a small 8x6 image, checked
// cycle by cycle against a frame-image reference model.
module tb_filter_window_5x5;

    localparam int DW = 8;
    localparam int H  = 8;
    localparam int V  = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_fs, i_de;
    logic [DW-1:0] i_data;
    logic          o_de, o_eof;
    logic [DW-1:0] o_x00, o_x01, o_x02, o_x03, o_x04;
    logic [DW-1:0] o_x10, o_x11, o_x12, o_x13, o_x14;
    logic [DW-1:0] o_x20, o_x21, o_x22, o_x23, o_x24;
    logic [DW-1:0] o_x30, o_x31, o_x32, o_x33, o_x34;
    logic [DW-1:0] o_x40, o_x41, o_x42, o_x43, o_x44;
    logic [DW-1:0] dw [5][5];

    int tests_run = 0;
    int fails     = 0;
    int n_de      = 0;
    int n_eof     = 0;

    // Reference model: current frame image, raster position and frame state.
    logic [DW-1:0] img [V][H];
    bit            m_active;
    int            m_r, m_c;
    logic [DW-1:0] exp_win [5][5];

    always #5 clk = ~clk;

    filter_window_5x5 #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rstn(rstn), .i_fs(i_fs), .i_de(i_de), .i_data(i_data),
        .o_de(o_de), .o_eof(o_eof),
        .o_x00(o_x00), .o_x01(o_x01), .o_x02(o_x02), .o_x03(o_x03), .o_x04(o_x04),
        .o_x10(o_x10), .o_x11(o_x11), .o_x12(o_x12), .o_x13(o_x13), .o_x14(o_x14),
        .o_x20(o_x20), .o_x21(o_x21), .o_x22(o_x22), .o_x23(o_x23), .o_x24(o_x24),
        .o_x30(o_x30), .o_x31(o_x31), .o_x32(o_x32), .o_x33(o_x33), .o_x34(o_x34),
        .o_x40(o_x40), .o_x41(o_x41), .o_x42(o_x42), .o_x43(o_x43), .o_x44(o_x44)
    );

    assign dw[0][0] = o_x00; assign dw[0][1] = o_x01; assign dw[0][2] = o_x02;
    assign dw[0][3] = o_x03; assign dw[0][4] = o_x04;
    assign dw[1][0] = o_x10; assign dw[1][1] = o_x11; assign dw[1][2] = o_x12;
    assign dw[1][3] = o_x13; assign dw[1][4] = o_x14;
    assign dw[2][0] = o_x20; assign dw[2][1] = o_x21; assign dw[2][2] = o_x22;
    assign dw[2][3] = o_x23; assign dw[2][4] = o_x24;
    assign dw[3][0] = o_x30; assign dw[3][1] = o_x31; assign dw[3][2] = o_x32;
    assign dw[3][3] = o_x33; assign dw[3][4] = o_x34;
    assign dw[4][0] = o_x40; assign dw[4][1] = o_x41; assign dw[4][2] = o_x42;
    assign dw[4][3] = o_x43; assign dw[4][4] = o_x44;

    task automatic model_reset();
        m_active = 0;
        m_r      = 0;
        m_c      = 0;
    endtask

    // One clock cycle: drive inputs, predict, clock, then check all outputs.
    task automatic cycle(input logic de, input logic fs, input logic [DW-1:0] d);
        bit ede, eeof;
        int cr, cc;
        ede = 0; eeof = 0; cr = 0; cc = 0;
        i_de = de; i_fs = fs; i_data = d;
        if (de && (fs || m_active)) begin
            if (fs) begin
                m_r = 0; m_c = 0;
            end
            m_active = 1;
            img[m_r][m_c] = d;
            if (m_r >= 4 && m_c >= 4) begin
                ede = 1; cr = m_r - 2; cc = m_c - 2;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        exp_win[r][c] = img[m_r-4+r][m_c-4+c];
            end
            if (m_r == V-1 && m_c == H-1) begin
                eeof = 1; m_active = 0; m_r = 0; m_c = 0;
            end else if (m_c == H-1) begin
                m_c = 0; m_r++;
            end else begin
                m_c++;
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (o_de !== ede) begin
            fails++;
            $display("[TB] FAIL o_de: got %b expected %b at t=%0t", o_de, ede, $time);
        end
        tests_run++;
        if (o_eof !== eeof) begin
            fails++;
            $display("[TB] FAIL o_eof: got %b expected %b at t=%0t", o_eof, eeof, $time);
        end
        if (o_eof === 1'b1) n_eof++;
        if (o_de === 1'b1) begin
            n_de++;
            $display("[TB] window centre (%0d,%0d) x22=%h", cr, cc, o_x22);
        end
        if (ede) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    tests_run++;
                    if (dw[r][c] !== exp_win[r][c]) begin
                        fails++;
                        $display("[TB] FAIL win_x%0d%0d: got %h expected %h", r, c,
                                 dw[r][c], exp_win[r][c]);
                    end
                end
            end
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests_run++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if (o_de !== 1'b0 || o_eof !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_flags: got de=%b eof=%b expected 0", name, o_de, o_eof);
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                tests_run++;
                if (dw[r][c] !== '0) begin
                    fails++;
                    $display("[TB] FAIL %s_x%0d%0d: got %h expected 00", name, r, c, dw[r][c]);
                end
            end
        end
    endtask

    // Random image pixel stream; gap_mode 0 none, 1 alternate, 2 random gaps.
    task automatic send_frame(input int gap_mode, input bit ramp);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                logic [DW-1:0] px;
                px = ramp ? DW'(r*16 + c) : DW'($urandom_range(0, 255));
                cycle(1'b1, (r == 0 && c == 0), px);
                if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
                    cycle(1'b0, 1'b0, DW'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_fs = 1'b0; i_de = 1'b0; i_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_ramp();
        logic [DW-1:0] first [5][5];
        bit got_first;
        got_first = 0;
        n_de = 0; n_eof = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                cycle(1'b1, (r == 0 && c == 0), DW'(r*16 + c));
                if (o_de === 1'b1 && !got_first) begin
                    got_first = 1;
                    first = dw;
                end
            end
        end
        cycle(1'b0, 1'b0, '0);
        check_count("ramp_windows", n_de, 8);
        check_count("ramp_eof", n_eof, 1);
        tests_run++;
        if (first[0][0] !== 8'h00 || first[0][4] !== 8'h04 || first[4][0] !== 8'h40 ||
            first[4][4] !== 8'h44 || first[2][2] !== 8'h22) begin
            fails++;
            $display("[TB] FAIL ramp_first: got %h %h %h %h %h expected 00 04 40 44 22",
                     first[0][0], first[0][4], first[4][0], first[4][4], first[2][2]);
        end
    endtask

    task automatic test_stall();
        n_de = 0; n_eof = 0;
        send_frame(1, 1'b1);
        check_count("stall_windows", n_de, 8);
        check_count("stall_eof", n_eof, 1);
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 3; f++) begin
            n_de = 0; n_eof = 0;
            send_frame(2, 1'b0);
            check_count("rand_windows", n_de, 8);
            check_count("rand_eof", n_eof, 1);
        end
    endtask

    task automatic test_abort();
        n_de = 0; n_eof = 0;
        for (int p = 0; p < 3*H + 5; p++)
            cycle(1'b1, (p == 0), DW'($urandom_range(0, 255)));
        check_count("abort_old_windows", n_de, 0);
        send_frame(2, 1'b0);
        check_count("abort_new_windows", n_de, 8);
        check_count("abort_eof", n_eof, 1);
    endtask

    task automatic test_pre_post();
        rstn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        n_de = 0; n_eof = 0;
        for (int p = 0; p < 20; p++)
            cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        check_count("pre_fs_windows", n_de, 0);
        send_frame(0, 1'b0);
        for (int p = 0; p < 20; p++)
            cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        check_count("post_windows", n_de, 8);
        check_count("post_eof_once", n_eof, 1);
    endtask

    task automatic test_reset_mid();
        n_de = 0;
        for (int p = 0; p < 4*H + 6; p++)
            cycle(1'b1, (p == 0), DW'($urandom_range(0, 255)));
        check_count("mid_pre_windows", n_de, 2);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        rstn = 1'b1;
        n_de = 0; n_eof = 0;
        for (int p = 0; p < 10; p++)
            cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        send_frame(2, 1'b0);
        check_count("after_reset_windows", n_de, 8);
        check_count("after_reset_eof", n_eof, 1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_random_gaps();
        test_abort();
        test_pre_post();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
